scan_scheduler: RTL and testbench
=================================

Name: scan_scheduler

Overview:
- Arbitrates three requesters (pilot, weapons, nav) for the single ARTAU radar scan resource in the ICMS design.
- Issues a one-cycle scan_for_target launch for the winner, then tracks ARTAU_state until the scan completes or times out.
- Blocks new scans while emergency_landing_alert from ECSU is high.
- Sits between the requesters and the ARTAU scan_for_target input inside ICMS.

Parameters:
TIMEOUT, 500, max cycles from launch to scan completion before abort (>=4)
AUTO_PERIOD, 1000, cycles between autonomous scan requests (used only with AUTO_SCAN_EN)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
req  input  3  scan requests: [0] pilot, [1] weapons, [2] nav; level, held until granted
ARTAU_state  input  2  ARTAU FSM state; 2'b00 = ARTAU idle, any other value = scan in progress
emergency_landing_alert  input  1  ECSU alert; inhibits new grants
scan_for_target  output  1  one-cycle launch pulse to ARTAU
grant  output  3  one-hot owner of the current scan; 0 when none
scan_done  output  1  one-cycle pulse: scan completed normally
scan_timeout  output  1  one-cycle pulse: scan aborted by timeout
busy  output  1  high in any state other than IDLE
sched_state  output  2  current FSM state encoding

Behaviour:
- Reset (async, RST=1): state IDLE, all outputs 0, timeout counter 0, round-robin pointer last=2 (so req[0] has first priority).
- All outputs are registered.
- FSM encodings: IDLE=00, LAUNCH=01, WAIT_START=10, WAIT_END=11.
- IDLE:
  - If emergency_landing_alert=0 and req!=0, pick the winner by round-robin, searching last+1, last+2, last+3 (mod 3).
  - Next cycle: state LAUNCH, grant=onehot(winner), scan_for_target=1, last=winner, timeout counter cleared.
  - If emergency_landing_alert=1, stay in IDLE; requests stay pending and nothing is granted.
- LAUNCH: lasts exactly one cycle, then WAIT_START. scan_for_target is high only in LAUNCH.
- WAIT_START: when sampled ARTAU_state!=00, go to WAIT_END.
- WAIT_END: when sampled ARTAU_state==00, go to IDLE next cycle. On that same cycle scan_done=1 and grant=0.
- Timeout counter:
  - Increments every cycle in LAUNCH, WAIT_START and WAIT_END.
  - When the counter equals TIMEOUT-1 and no completion is sampled that cycle, go to IDLE next cycle with scan_timeout=1 and grant=0.
  - If completion and timeout occur in the same cycle, completion wins: scan_done=1, scan_timeout=0.
- grant stays stable from LAUNCH through the last WAIT_END cycle. Changes on req while busy are ignored.
- emergency_landing_alert rising mid-scan does not abort the scan; it only blocks the next grant.
- Back-to-back scans: the earliest new grant is the cycle after the scan_done/scan_timeout cycle, because arbitration runs in IDLE.
- Latency: req sampled in IDLE at cycle N gives grant and scan_for_target at N+1.
- Reset asserted mid-scan: all outputs drop to 0 immediately. No scan_done or scan_timeout pulse is generated.

Optional Feature:
- Macro AUTO_SCAN_EN.
- When defined:
  - An internal period counter counts cycles in any state and sets an internal auto_req when it reaches AUTO_PERIOD-1, then wraps to 0.
  - auto_req acts as a 4th requester with lowest fixed priority: granted only when req==0 in IDLE and emergency_landing_alert=0.
  - When auto_req is granted, grant stays 3'b000, busy=1, and the scan runs normally. auto_req clears at LAUNCH.
  - The round-robin pointer is not updated by auto scans.
  - The period counter resets to 0 on RST.
- When undefined: no auto requester, no period counter, and scans occur only on req.

Test Plan:
1. Single request: req=3'b001; ARTAU_state goes 01 three cycles after launch and returns to 00 ten cycles later -> grant=001 and scan_for_target pulse one cycle after req; scan_done one cycle after ARTAU_state returns to 00; grant then 0.
2. Round-robin: req=3'b111 held for three scans -> grants in order 001, 010, 100, then 001 again; exactly one scan_for_target pulse per scan.
3. Timeout, TIMEOUT=8: ARTAU_state held at 00 after launch -> scan_timeout=1 exactly 8 cycles after LAUNCH; scan_done never asserts; FSM back in IDLE.
4. Emergency inhibit: emergency_landing_alert=1 with req=3'b010 -> no grant for 20 cycles; drop the alert -> grant=010 on the next cycle. Separately, raise the alert during WAIT_END -> the scan completes with scan_done=1.
5. Async reset during WAIT_END: assert RST between clock edges -> grant, busy and sched_state read 0 immediately; no scan_done or scan_timeout pulse appears.
6. AUTO_SCAN_EN with AUTO_PERIOD=16 and req=0 -> scan_for_target pulse every 16 cycles (ARTAU completing quickly) with grant=000; a pending req[1] in the same IDLE cycle wins over auto_req.

Source files
------------

// File: rtl/scan_scheduler.sv
// Round-robin scheduler for the ARTAU radar scan: launches one scan at a time and tracks completion or timeout.
// Optional autonomous periodic scan requester is enabled by defining AUTO_SCAN_EN.
module scan_scheduler #(
  parameter int TIMEOUT     = 500,
  parameter int AUTO_PERIOD = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] req,
  input  logic [1:0] ARTAU_state,
  input  logic       emergency_landing_alert,
  output logic       scan_for_target,
  output logic [2:0] grant,
  output logic       scan_done,
  output logic       scan_timeout,
  output logic       busy,
  output logic [1:0] sched_state
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  if (TIMEOUT < 4) begin : g_chk_timeout
    $error("scan_scheduler: TIMEOUT must be at least 4");
  end
  if (AUTO_PERIOD < 2) begin : g_chk_period
    $error("scan_scheduler: AUTO_PERIOD must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LAUNCH     = 2'b01,
    WAIT_START = 2'b10,
    WAIT_END   = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    last_q, last_d;
  logic [2:0]    grant_q, grant_d;
  logic          launch_q, launch_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic          busy_q, busy_d;

  logic          rr_found;
  logic [1:0]    rr_winner;
  logic          auto_pending;
  logic          completion;

  function automatic logic [1:0] rr_pos(input logic [1:0] base, input int unsigned step);
    int unsigned s;
    s = (int'(base) + step) % 3;
    return s[1:0];
  endfunction

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_q;
    for (int unsigned k = 1; k <= 3; k++) begin
      if (!rr_found && req[rr_pos(last_q, k)]) begin
        rr_found  = 1'b1;
        rr_winner = rr_pos(last_q, k);
      end
    end
  end

`ifdef AUTO_SCAN_EN
  localparam int PW = $clog2(AUTO_PERIOD);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(AUTO_PERIOD - 1);

  logic [PW-1:0] period_q, period_d;
  logic          auto_req_q, auto_req_d;
  logic          auto_take;

  assign auto_pending = auto_req_q;
  assign auto_take    = (state_q == IDLE) && !emergency_landing_alert && !rr_found && auto_req_q;

  // A new period tick takes precedence over clearing on launch.
  always_comb begin
    period_d   = (period_q == PERIOD_LAST) ? '0 : period_q + PW'(1);
    auto_req_d = auto_req_q;
    if (auto_take) begin
      auto_req_d = 1'b0;
    end
    if (period_q == PERIOD_LAST) begin
      auto_req_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      period_q   <= '0;
      auto_req_q <= 1'b0;
    end else begin
      period_q   <= period_d;
      auto_req_q <= auto_req_d;
    end
  end
`else
  assign auto_pending = 1'b0;
`endif

  assign completion = (state_q == WAIT_END) && (ARTAU_state == 2'b00);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_d  = grant_q;
    launch_d = 1'b0;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = 3'b000;
        if (!emergency_landing_alert) begin
          if (rr_found) begin
            state_d  = LAUNCH;
            grant_d  = 3'b001 << rr_winner;
            last_d   = rr_winner;
            launch_d = 1'b1;
            cnt_d    = '0;
          end else if (auto_pending) begin
            // Autonomous scans own no requester line, so grant stays zero.
            state_d  = LAUNCH;
            launch_d = 1'b1;
            cnt_d    = '0;
          end
        end
      end
      default: begin
        cnt_d = cnt_q + CW'(1);
        if (completion) begin
          state_d = IDLE;
          grant_d = 3'b000;
          done_d  = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          grant_d = 3'b000;
          tmo_d   = 1'b1;
        end else if (state_q == LAUNCH) begin
          state_d = WAIT_START;
        end else if (state_q == WAIT_START && ARTAU_state != 2'b00) begin
          state_d = WAIT_END;
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 2'd2;
      grant_q  <= 3'b000;
      launch_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      launch_q <= launch_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
    end
  end

  assign scan_for_target = launch_q;
  assign grant           = grant_q;
  assign scan_done       = done_q;
  assign scan_timeout    = tmo_q;
  assign busy            = busy_q;
  assign sched_state     = state_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler: scoreboard queues of expected grants and scan endings.
// A second instance with TIMEOUT=8 exercises the abort path.
module tb_scan_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] req;
  logic [1:0] artau;
  logic       alert;

  logic       sft, done, tmo, busy;
  logic [2:0] grant;
  logic [1:0] sstate;
  logic       t_sft, t_done, t_tmo, t_busy;
  logic [2:0] t_grant;
  logic [1:0] t_sstate;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [2:0] exp_grant_q[$];
  logic [1:0] exp_end_q[$];   // {scan_done, scan_timeout}

  scan_scheduler #(.TIMEOUT(500), .AUTO_PERIOD(16)) dut (
    .CLK(CLK), .RST(RST), .req(req), .ARTAU_state(artau),
    .emergency_landing_alert(alert), .scan_for_target(sft), .grant(grant),
    .scan_done(done), .scan_timeout(tmo), .busy(busy), .sched_state(sstate)
  );

  scan_scheduler #(.TIMEOUT(8), .AUTO_PERIOD(16)) dut_to (
    .CLK(CLK), .RST(RST), .req(req), .ARTAU_state(artau),
    .emergency_landing_alert(alert), .scan_for_target(t_sft), .grant(t_grant),
    .scan_done(t_done), .scan_timeout(t_tmo), .busy(t_busy), .sched_state(t_sstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1; req = 3'b000; artau = 2'b00; alert = 1'b0;
    step(); step();
    RST = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1; req = 3'b000; artau = 2'b00; alert = 1'b0;
    step();
    n_cmp++;
    if ({sft, grant, done, tmo, busy, sstate} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 000000000", {sft, grant, done, tmo, busy, sstate});
    end
    n_cmp++;
    if ({t_sft, t_grant, t_done, t_tmo, t_busy, t_sstate} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_to: got %b, required 000000000", {t_sft, t_grant, t_done, t_tmo, t_busy, t_sstate});
    end
    RST = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || sft !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_no_req: busy=%b sft=%b, required 0 0", busy, sft);
    end
  endtask

  task automatic test_single();
    logic [2:0] g;
    logic [1:0] e;
    do_reset();
    exp_grant_q.push_back(3'b001);
    exp_end_q.push_back(2'b10);
    req = 3'b001;
    step();
    g = exp_grant_q.pop_front();
    n_cmp++;
    if (sft !== 1'b1 || grant !== g) begin
      n_fail++;
      $display("FAIL single_launch: sft=%b grant=%b, required sft=1 grant=%b", sft, grant, g);
    end
    n_cmp++;
    if (sstate !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_launch_state: state=%b busy=%b, required 01 1", sstate, busy);
    end
    req = 3'b000;
    step();
    n_cmp++;
    if (sft !== 1'b0 || sstate !== 2'b10) begin
      n_fail++;
      $display("FAIL single_wait_start: sft=%b state=%b, required 0 10", sft, sstate);
    end
    step();
    artau = 2'b01;
    repeat (10) step();
    n_cmp++;
    if (sstate !== 2'b11 || grant !== g) begin
      n_fail++;
      $display("FAIL single_wait_end: state=%b grant=%b, required 11 %b", sstate, grant, g);
    end
    artau = 2'b00;
    step();
    e = exp_end_q.pop_front();
    n_cmp++;
    if ({done, tmo} !== e || grant !== 3'b000 || busy !== 1'b0 || sstate !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: done/tmo=%b grant=%b busy=%b state=%b, required %b 000 0 00",
               {done, tmo}, grant, busy, sstate, e);
    end
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b one cycle later, required 0", done);
    end
    $display("single: launch grant=%b then scan_done", g);
  endtask

  task automatic test_round_robin();
    logic [2:0] g;
    do_reset();
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b001);
    req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      step();
      g = exp_grant_q.pop_front();
      n_cmp++;
      if (sft !== 1'b1 || grant !== g) begin
        n_fail++;
        $display("FAIL rr_launch%0d: sft=%b grant=%b, required sft=1 grant=%b", s, sft, grant, g);
      end
      artau = 2'b01;
      step();
      n_cmp++;
      if (sft !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_single_pulse%0d: sft=%b, required 0", s, sft);
      end
      step();
      artau = 2'b00;
      step();
      n_cmp++;
      if (done !== 1'b1 || grant !== 3'b000) begin
        n_fail++;
        $display("FAIL rr_done%0d: done=%b grant=%b, required 1 000", s, done, grant);
      end
      $display("rr: scan %0d grant=%b", s, g);
    end
    req = 3'b000;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] g;
    logic [1:0] e;
    int bad;
    do_reset();
    exp_grant_q.push_back(3'b010);
    exp_end_q.push_back(2'b01);
    req = 3'b010;
    step();
    g = exp_grant_q.pop_front();
    n_cmp++;
    if (t_sft !== 1'b1 || t_grant !== g) begin
      n_fail++;
      $display("FAIL tmo_launch: sft=%b grant=%b, required 1 %b", t_sft, t_grant, g);
    end
    req = 3'b000;
    bad = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (t_tmo !== 1'b0 || t_done !== 1'b0 || t_busy !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL tmo_early: %0d bad cycles before the limit, required 0", bad);
    end
    step();
    e = exp_end_q.pop_front();
    n_cmp++;
    if ({t_done, t_tmo} !== e || t_grant !== 3'b000 || t_sstate !== 2'b00) begin
      n_fail++;
      $display("FAIL tmo_fire: done/tmo=%b grant=%b state=%b, required %b 000 00",
               {t_done, t_tmo}, t_grant, t_sstate, e);
    end
    step();
    n_cmp++;
    if (t_tmo !== 1'b0 || t_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_pulse: tmo=%b busy=%b, required 0 0", t_tmo, t_busy);
    end
    $display("timeout: scan_timeout 8 cycles after launch");

    // Completion sampled on the same cycle as the limit: completion wins.
    exp_grant_q.push_back(3'b100);
    exp_end_q.push_back(2'b10);
    req = 3'b100;
    step();
    g = exp_grant_q.pop_front();
    n_cmp++;
    if (t_sft !== 1'b1 || t_grant !== g) begin
      n_fail++;
      $display("FAIL tie_launch: sft=%b grant=%b, required 1 %b", t_sft, t_grant, g);
    end
    req = 3'b000;
    artau = 2'b01;
    repeat (7) step();
    artau = 2'b00;
    step();
    e = exp_end_q.pop_front();
    n_cmp++;
    if ({t_done, t_tmo} !== e) begin
      n_fail++;
      $display("FAIL tie_done_wins: done/tmo=%b, required %b", {t_done, t_tmo}, e);
    end
    $display("timeout: tie resolved as done/tmo=%b", {t_done, t_tmo});
  endtask

  task automatic test_emergency();
    logic [2:0] g;
    int bad;
    do_reset();
    alert = 1'b1;
    req = 3'b010;
    bad = 0;
    repeat (20) begin
      step();
      if (grant !== 3'b000 || sft !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL emerg_inhibit: %0d cycles granted under alert, required 0", bad);
    end
    exp_grant_q.push_back(3'b010);
    alert = 1'b0;
    step();
    g = exp_grant_q.pop_front();
    n_cmp++;
    if (sft !== 1'b1 || grant !== g) begin
      n_fail++;
      $display("FAIL emerg_release: sft=%b grant=%b, required 1 %b", sft, grant, g);
    end
    req = 3'b001;
    artau = 2'b01;
    step();
    step();
    alert = 1'b1;
    step();
    n_cmp++;
    if (grant !== g || sstate !== 2'b11) begin
      n_fail++;
      $display("FAIL emerg_stable: grant=%b state=%b, required %b 11", grant, sstate, g);
    end
    artau = 2'b00;
    step();
    n_cmp++;
    if (done !== 1'b1 || tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL emerg_complete: done=%b tmo=%b, required 1 0", done, tmo);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || sft !== 1'b0) begin
      n_fail++;
      $display("FAIL emerg_block_next: busy=%b sft=%b, required 0 0", busy, sft);
    end
    exp_grant_q.push_back(3'b001);
    alert = 1'b0;
    step();
    g = exp_grant_q.pop_front();
    n_cmp++;
    if (sft !== 1'b1 || grant !== g) begin
      n_fail++;
      $display("FAIL emerg_next_grant: sft=%b grant=%b, required 1 %b", sft, grant, g);
    end
    req = 3'b000;
    $display("emergency: inhibit held, mid-scan alert let scan complete");
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    req = 3'b001;
    step();
    req = 3'b000;
    artau = 2'b01;
    step();
    step();
    n_cmp++;
    if (sstate !== 2'b11) begin
      n_fail++;
      $display("FAIL arst_precond: state=%b, required 11", sstate);
    end
    #3;
    RST = 1'b1;
    #1;
    n_cmp++;
    if (grant !== 3'b000 || busy !== 1'b0 || sstate !== 2'b00 || sft !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: grant=%b busy=%b state=%b sft=%b, required 000 0 00 0",
               grant, busy, sstate, sft);
    end
    artau = 2'b00;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (done !== 1'b0 || tmo !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL arst_no_pulse: %0d cycles with done/timeout, required 0", bad);
    end
    $display("async reset: outputs cleared mid-scan");
  endtask

`ifdef AUTO_SCAN_EN
  task automatic test_auto();
    logic [2:0] g;
    int t_prev;
    int waited;
    do_reset();
    waited = 0;
    while (sft !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    n_cmp++;
    if (sft !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_first: no auto launch within 40 cycles, required a launch");
    end
    for (int n = 0; n < 3; n++) begin
      exp_grant_q.push_back(3'b000);
      g = exp_grant_q.pop_front();
      n_cmp++;
      if (grant !== g || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL auto_grant%0d: grant=%b busy=%b, required %b 1", n, grant, busy, g);
      end
      t_prev = cyc;
      artau = 2'b01;
      step();
      step();
      artau = 2'b00;
      step();
      if (n < 2) begin
        waited = 0;
        step();
        while (sft !== 1'b1 && waited < 40) begin
          step();
          waited++;
        end
        n_cmp++;
        if (cyc - t_prev !== 16) begin
          n_fail++;
          $display("FAIL auto_period%0d: interval %0d, required 16", n, cyc - t_prev);
        end
        $display("auto: scan %0d interval %0d", n, cyc - t_prev);
      end
    end
    repeat (12) step();
    exp_grant_q.push_back(3'b010);
    req = 3'b010;
    step();
    g = exp_grant_q.pop_front();
    n_cmp++;
    if (sft !== 1'b1 || grant !== g) begin
      n_fail++;
      $display("FAIL auto_req_wins: sft=%b grant=%b, required 1 %b", sft, grant, g);
    end
    req = 3'b000;
    $display("auto: pending req grant=%b over auto", grant);
  endtask
`endif

  initial begin
    RST = 1'b1; req = 3'b000; artau = 2'b00; alert = 1'b0;
    test_reset();
`ifdef AUTO_SCAN_EN
    test_auto();
`else
    test_single();
    test_round_robin();
    test_timeout();
    test_emergency();
    test_async_reset();
`endif
    n_cmp++;
    if (exp_grant_q.size() !== 0 || exp_end_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0/0",
               exp_grant_q.size(), exp_end_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
